// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers producer bursts and drains them one byte
// at a time over the level-en / one-cycle-done handshake, with optional idle gap.
//
//   state | meaning
//   IDLE  | tx_en low; pops the head byte as soon as the FIFO is non-empty
//   SEND  | tx_en high, tx_data frozen; waiting for tx_done
//   GAP   | forced idle after a byte, gap counts down to 1 before IDLE
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_en,
    output logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    state_t              state;
    state_t              state_nxt;
    logic [GAP_W-1:0]    gap;
    logic [GAP_W-1:0]    gap_nxt;
    logic                tx_en_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;
    logic                pop;
    logic                wr_accept;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign pop       = (state == IDLE) && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO can still take a write
    assign wr_accept = wr_en && (!full || pop);

    // Contents are not reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            gap      <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            overflow <= wr_en && !wr_accept;
            state    <= state_nxt;
            gap      <= gap_nxt;
            tx_en    <= tx_en_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_nxt     = gap;
        tx_en_nxt   = tx_en;
        tx_data_nxt = tx_data;
        case (state)
            IDLE: begin
                if (pop) begin
                    tx_data_nxt = mem[rd_ptr[DEPTH_LOG2-1:0]];
                    tx_en_nxt   = 1'b1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    tx_en_nxt = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_W'(GAP_CYCLES);
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap - 1'b1;
                if (gap == GAP_W'(1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference, on GAP_CYCLES 0 and 3.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_done = 1'b0;

    logic       full0, empty0, overflow0, tx_en0;
    logic [4:0] count0;
    logic [7:0] tx_data0;
    logic       full3, empty3, overflow3, tx_en3;
    logic [4:0] count3;
    logic [7:0] tx_data3;

    typedef struct packed {
        logic       full;
        logic       empty;
        logic [4:0] count;
        logic       ovf;
        logic       en;
        logic [7:0] data;
    } obs_t;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       done;
        obs_t       exp;
    } vec_t;

    obs_t o0, o3;
    assign o0 = {full0, empty0, count0, overflow0, tx_en0, tx_data0};
    assign o3 = {full3, empty3, count3, overflow3, tx_en3, tx_data3};

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .GAP_CYCLES(0)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full0), .empty(empty0), .count(count0), .overflow(overflow0),
        .tx_en(tx_en0), .tx_data(tx_data0), .tx_done(tx_done)
    );

    uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .GAP_CYCLES(3)) dut_g (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full3), .empty(empty3), .count(count3), .overflow(overflow3),
        .tx_en(tx_en3), .tx_data(tx_data3), .tx_done(tx_done)
    );

    function automatic obs_t mk_obs(input logic f, input logic e, input logic [4:0] c,
                                    input logic ov, input logic en, input logic [7:0] d);
        obs_t r;
        r.full = f; r.empty = e; r.count = c; r.ovf = ov; r.en = en; r.data = d;
        return r;
    endfunction

    function automatic obs_t cur(input bit s);
        return s ? o3 : o0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        chk($sformatf("%s.full", tag),     32'(a.full),  32'(e.full));
        chk($sformatf("%s.empty", tag),    32'(a.empty), 32'(e.empty));
        chk($sformatf("%s.count", tag),    32'(a.count), 32'(e.count));
        chk($sformatf("%s.overflow", tag), 32'(a.ovf),   32'(e.ovf));
        chk($sformatf("%s.tx_en", tag),    32'(a.en),    32'(e.en));
        chk($sformatf("%s.tx_data", tag),  32'(a.data),  32'(e.data));
    endtask

    task automatic do_reset();
        rstn = 1'b0; wr_en = 1'b0; tx_done = 1'b0; wr_data = 8'h00;
        @(negedge clk);
        chk_obs("reset_g0", o0, mk_obs(0, 1, 0, 0, 0, 8'h00));
        chk_obs("reset_g3", o3, mk_obs(0, 1, 0, 0, 0, 8'h00));
        rstn = 1'b1;
    endtask

    // Acts as uart_tx: done after two tx_en-high cycles, plus a spurious done on
    // the first low cycle after each byte. Writes n_wr bytes from base meanwhile.
    task automatic drain_check(input string tag, input bit s, input int n_wr,
                               input logic [7:0] base, input int gap_exp);
        logic [7:0] got[$];
        obs_t o;
        int hi_cnt, low_run;
        bit seen_high, saw_full;
        o = cur(s);
        hi_cnt = o.en ? 1 : 0;
        seen_high = o.en;
        low_run = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 400 && got.size() < exp_q.size(); cyc++) begin
            wr_en   = (cyc < n_wr);
            wr_data = 8'(base + 8'(cyc));
            tx_done = (o.en && hi_cnt >= 2) || (!o.en && low_run == 1);
            @(negedge clk);
            o = cur(s);
            if (o.full) saw_full = 1'b1;
            if (o.en) begin
                if (hi_cnt == 0) begin
                    got.push_back(o.data);
                    if (seen_high)
                        chk($sformatf("%s.low_cycles", tag), 32'(low_run), 32'(gap_exp));
                end
                hi_cnt++;
                seen_high = 1'b1;
                low_run = 0;
            end else begin
                hi_cnt = 0;
                low_run++;
            end
        end
        wr_en = 1'b0;
        tx_done = 1'b0;
        chk($sformatf("%s.bytes_sent", tag), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        if (n_wr > 0)
            chk($sformatf("%s.never_full", tag), 32'(saw_full), 32'(0));
    endtask

    task automatic run_random(input bit s, input int gap, input int ncyc);
        logic [7:0] q[$];
        logic [7:0] m_data;
        bit m_en, m_ovf, can_pop, accept;
        int hold;
        obs_t o;
        m_data = 8'h00; m_en = 1'b0; m_ovf = 1'b0; hold = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            o = cur(s);
            wr_en   = ($urandom_range(0, 99) < (((cyc / 200) % 2) ? 85 : 30));
            wr_data = 8'($urandom);
            tx_done = o.en ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            can_pop = !m_en && hold == 0 && q.size() > 0;
            accept  = wr_en && (q.size() < 16 || can_pop);
            if (can_pop) begin
                m_data = q.pop_front();
                m_en = 1'b1;
            end else if (m_en && tx_done) begin
                m_en = 1'b0;
                hold = gap;
            end else if (!m_en && hold > 0) begin
                hold--;
            end
            if (accept) q.push_back(wr_data);
            m_ovf = wr_en && !accept;
            @(negedge clk);
            chk_obs($sformatf("rand_g%0d_c%0d", gap, cyc), cur(s),
                    mk_obs(q.size() == 16, q.size() == 0, 5'(q.size()), m_ovf, m_en, m_data));
        end
        wr_en = 1'b0;
        tx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        tbl[0] = '{1'b1, 8'h55, 1'b0, mk_obs(0, 0, 1, 0, 0, 8'h00)};
        tbl[1] = '{1'b0, 8'h00, 1'b0, mk_obs(0, 1, 0, 0, 1, 8'h55)};
        tbl[2] = '{1'b0, 8'h00, 1'b0, mk_obs(0, 1, 0, 0, 1, 8'h55)};
        tbl[3] = '{1'b0, 8'h00, 1'b1, mk_obs(0, 1, 0, 0, 0, 8'h55)};
        tbl[4] = '{1'b0, 8'h00, 1'b1, mk_obs(0, 1, 0, 0, 0, 8'h55)};
        tbl[5] = '{1'b1, 8'hA3, 1'b0, mk_obs(0, 0, 1, 0, 0, 8'h55)};
        tbl[6] = '{1'b1, 8'h3C, 1'b1, mk_obs(0, 0, 1, 0, 1, 8'hA3)};
        tbl[7] = '{1'b0, 8'h00, 1'b1, mk_obs(0, 0, 1, 0, 0, 8'hA3)};
        tbl[8] = '{1'b0, 8'h00, 1'b0, mk_obs(0, 1, 0, 0, 1, 8'h3C)};
        tbl[9] = '{1'b0, 8'h00, 1'b1, mk_obs(0, 1, 0, 0, 0, 8'h3C)};

        // Single byte and spurious-done vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = tbl[i].we; wr_data = tbl[i].wd; tx_done = tbl[i].done;
            @(negedge clk);
            chk_obs($sformatf("vec%0d", i), o0, tbl[i].exp);
        end
        wr_en = 1'b0; tx_done = 1'b0;

        // Asynchronous reset while a byte is in flight
        do_reset();
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("async.tx_en_before", 32'(tx_en0), 32'(1));
        #2 rstn = 1'b0;
        #1;
        chk("async.tx_en", 32'(tx_en0), 32'(0));
        chk("async.empty", 32'(empty0), 32'(1));
        chk("async.count", 32'(count0), 32'(0));
        chk("async.tx_data", 32'(tx_data0), 32'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Burst of 16 through a live uart_tx
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h41 + i));
        drain_check("burst", 1'b0, 16, 8'h41, 1);

        // Overflow with tx_done held low, then write+pop on a full FIFO
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            @(negedge clk);
        end
        chk_obs("ovf.after17", o0, mk_obs(1, 0, 16, 0, 1, 8'h80));
        wr_data = 8'h91;
        @(negedge clk);
        chk_obs("ovf.after18", o0, mk_obs(1, 0, 16, 1, 1, 8'h80));
        wr_en = 1'b0;
        @(negedge clk);
        chk_obs("ovf.pulse_end", o0, mk_obs(1, 0, 16, 0, 1, 8'h80));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk_obs("fullpop.idle", o0, mk_obs(1, 0, 16, 0, 0, 8'h80));
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk_obs("fullpop.after", o0, mk_obs(1, 0, 16, 0, 1, 8'h81));
        exp_q.delete();
        for (int i = 2; i < 17; i++) exp_q.push_back(8'(8'h80 + i));
        exp_q.push_back(8'hA5);
        drain_check("fullpop_drain", 1'b0, 0, 8'h00, 1);

        // GAP_CYCLES=3: four low cycles between bytes, spurious done in GAP
        do_reset();
        exp_q.delete();
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        drain_check("gap3", 1'b1, 2, 8'h61, 4);

        do_reset();
        run_random(1'b0, 0, 1500);
        do_reset();
        run_random(1'b1, 3, 1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
